// File: rtl/evict_writeback_queue_if.sv
// Eviction input and memory writeback handshake bundle for evict_writeback_queue.
// master: the queue side; slave: cache/memory environment side.
interface evict_writeback_queue_if #(
   parameter int unsigned ADDR_WIDTH = 8
);
   logic                  evict_valid;
   logic [ADDR_WIDTH-1:0] evict_addr;
   logic                  mem_req;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_ack;

   modport master (
      input  evict_valid,
      input  evict_addr,
      input  mem_ack,
      output mem_req,
      output mem_addr
   );

   modport slave (
      output evict_valid,
      output evict_addr,
      output mem_ack,
      input  mem_req,
      input  mem_addr
   );
endinterface

// File: rtl/evict_writeback_queue.sv
// Evicted-address queue draining to memory over a single-outstanding req/ack handshake.
// Circular buffer plus count; drops on full are counted (saturating) and flagged sticky.
// Optional macro WB_COALESCE_EN: discard evictions that match any queued entry.
module evict_writeback_queue #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   evict_writeback_queue_if.master      bus,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   pending_count,
   output logic                         overflow,
   output logic [CNT_WIDTH-1:0]         drop_count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CW    = $clog2(DEPTH+1);

   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

   state_t                state_q, state_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic                  mem_req_q;
   logic                  full_q;
   logic                  overflow_q, overflow_d;
   logic [CNT_WIDTH-1:0]  drop_q, drop_d;
   logic [ADDR_WIDTH-1:0] entry_q [DEPTH];

   logic                  dup;
   logic                  push;
   logic                  drop;
   logic                  pop;

   // Next-state, pointer, count and status computation
   always_comb begin
      state_d    = state_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      mem_addr_d = mem_addr_q;
      overflow_d = overflow_q;
      drop_d     = drop_q;
      dup        = 1'b0;

`ifdef WB_COALESCE_EN
      for (int i = 0; i < int'(DEPTH); i++) begin
         if ((CW'(i) < count_q) &&
             (entry_q[rd_ptr_q + PTR_W'(i)] == bus.evict_addr))
            dup = 1'b1;
      end
`endif

      // Full is judged on the registered count, so a same-cycle pop never frees a slot
      push = bus.evict_valid && !dup && (count_q != CW'(DEPTH));
      drop = bus.evict_valid && !dup && (count_q == CW'(DEPTH));
      pop  = (state_q == REQ) && bus.mem_ack;

      if (push)
         wr_ptr_d = wr_ptr_q + PTR_W'(1);

      if (drop) begin
         overflow_d = 1'b1;
         if (drop_q != {CNT_WIDTH{1'b1}})
            drop_d = drop_q + CNT_WIDTH'(1);
      end

      count_d = count_q + CW'(push) - CW'(pop);

      unique case (state_q)
         IDLE: begin
            if (count_q != CW'(0)) begin
               state_d    = REQ;
               mem_addr_d = entry_q[rd_ptr_q];
            end
         end
         REQ: begin
            if (bus.mem_ack) begin
               rd_ptr_d = rd_ptr_q + PTR_W'(1);
               // Next head already stored when more than one entry remains: no bubble
               if (count_q > CW'(1))
                  mem_addr_d = entry_q[rd_ptr_q + PTR_W'(1)];
               else
                  state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         mem_addr_q <= '0;
         mem_req_q  <= 1'b0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         mem_addr_q <= mem_addr_d;
         mem_req_q  <= (state_d == REQ);
         full_q     <= (count_d == CW'(DEPTH));
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
      end
   end

   // Entry storage; validity is tracked by count, so no reset is needed
   always_ff @(posedge clk) begin
      if (!reset && push)
         entry_q[wr_ptr_q] <= bus.evict_addr;
   end

   assign bus.mem_req    = mem_req_q;
   assign bus.mem_addr   = mem_addr_q;
   assign full           = full_q;
   assign pending_count  = count_q;
   assign overflow       = overflow_q;
   assign drop_count     = drop_q;
endmodule

// File: tb/tb_evict_writeback_queue.sv
// Directed bench for evict_writeback_queue (DEPTH=4, ADDR_WIDTH=8).
module tb_evict_writeback_queue;
   logic        clk;
   logic        reset;
   logic        full;
   logic [2:0]  pending_count;
   logic        overflow;
   logic [15:0] drop_count;
   int          total;
   int          bad;

   evict_writeback_queue_if #(.ADDR_WIDTH(8)) bus ();

   evict_writeback_queue #(
      .ADDR_WIDTH(8),
      .DEPTH(4),
      .CNT_WIDTH(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .full(full),
      .pending_count(pending_count),
      .overflow(overflow),
      .drop_count(drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then settle 1 time unit before driving/sampling
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.evict_valid = 1'b0;
      bus.evict_addr  = 8'h00;
      bus.mem_ack     = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk("rst_mem_req",  32'(bus.mem_req),   32'h0);
      chk("rst_mem_addr", 32'(bus.mem_addr),  32'h0);
      chk("rst_full",     32'(full),          32'h0);
      chk("rst_pending",  32'(pending_count), 32'h0);
      chk("rst_overflow", 32'(overflow),      32'h0);
      chk("rst_drop",     32'(drop_count),    32'h0);

      // Single push with ack tied high
      bus.mem_ack = 1'b1;
      bus.evict_valid = 1'b1; bus.evict_addr = 8'h11;
      tick();
      bus.evict_valid = 1'b0;
      chk("t1_pending_after_push", 32'(pending_count), 32'h1);
      chk("t1_req_latency",        32'(bus.mem_req),   32'h0);
      tick();
      chk("t1_req",      32'(bus.mem_req),   32'h1);
      chk("t1_addr",     32'(bus.mem_addr),  32'h11);
      tick();
      chk("t1_req_done", 32'(bus.mem_req),   32'h0);
      chk("t1_pending0", 32'(pending_count), 32'h0);
      chk("t1_addr_hold",32'(bus.mem_addr),  32'h11);
      bus.mem_ack = 1'b0;

      // Three back-to-back pushes, then ordered drain without bubbles
      bus.evict_valid = 1'b1; bus.evict_addr = 8'h11; tick();
      bus.evict_addr = 8'h22; tick();
      bus.evict_addr = 8'h33; tick();
      bus.evict_valid = 1'b0;
      chk("t2_pending3", 32'(pending_count), 32'h3);
      chk("t2_req",      32'(bus.mem_req),   32'h1);
      chk("t2_head",     32'(bus.mem_addr),  32'h11);
      tick();
      chk("t2_head_hold",32'(bus.mem_addr),  32'h11);
      bus.mem_ack = 1'b1;
      tick();
      chk("t2_second_req", 32'(bus.mem_req),   32'h1);
      chk("t2_second",     32'(bus.mem_addr),  32'h22);
      chk("t2_pending2",   32'(pending_count), 32'h2);
      tick();
      chk("t2_third_req",  32'(bus.mem_req),   32'h1);
      chk("t2_third",      32'(bus.mem_addr),  32'h33);
      tick();
      chk("t2_idle_req",   32'(bus.mem_req),   32'h0);
      chk("t2_pending0",   32'(pending_count), 32'h0);
      bus.mem_ack = 1'b0;

      // Overflow: push 0x01..0x06 into a 4-deep queue
      bus.evict_valid = 1'b1;
      bus.evict_addr = 8'h01; tick();
      bus.evict_addr = 8'h02; tick();
      bus.evict_addr = 8'h03; tick();
      chk("t3_not_full", 32'(full), 32'h0);
      bus.evict_addr = 8'h04; tick();
      chk("t3_full", 32'(full), 32'h1);
      bus.evict_addr = 8'h05; tick();
      bus.evict_addr = 8'h06; tick();
      bus.evict_valid = 1'b0;
      chk("t3_overflow", 32'(overflow),      32'h1);
      chk("t3_drop",     32'(drop_count),    32'h2);
      chk("t3_pending",  32'(pending_count), 32'h4);
      chk("t3_head",     32'(bus.mem_addr),  32'h01);
      bus.mem_ack = 1'b1;
      tick(); chk("t3_drain2", 32'(bus.mem_addr), 32'h02);
      tick(); chk("t3_drain3", 32'(bus.mem_addr), 32'h03);
      tick(); chk("t3_drain4", 32'(bus.mem_addr), 32'h04);
      tick();
      chk("t3_drained_req",  32'(bus.mem_req),   32'h0);
      chk("t3_drained_cnt",  32'(pending_count), 32'h0);
      chk("t3_drained_full", 32'(full),          32'h0);
      bus.mem_ack = 1'b0;

      // Full queue: push 0x55 on the same cycle as an ack is still dropped
      bus.evict_valid = 1'b1;
      bus.evict_addr = 8'h41; tick();
      bus.evict_addr = 8'h42; tick();
      bus.evict_addr = 8'h43; tick();
      bus.evict_addr = 8'h44; tick();
      chk("t4_full", 32'(full), 32'h1);
      bus.evict_addr = 8'h55;
      bus.mem_ack = 1'b1;
      tick();
      bus.evict_valid = 1'b0;
      bus.mem_ack = 1'b0;
      chk("t4_pending3", 32'(pending_count), 32'h3);
      chk("t4_drop",     32'(drop_count),    32'h3);
      chk("t4_full_clr", 32'(full),          32'h0);
      chk("t4_next",     32'(bus.mem_addr),  32'h42);

      // Reset with two entries queued and a request in flight
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      chk("t5_pending2", 32'(pending_count), 32'h2);
      chk("t5_req",      32'(bus.mem_req),   32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5_req",      32'(bus.mem_req),   32'h0);
      chk("t5_pending",  32'(pending_count), 32'h0);
      chk("t5_overflow", 32'(overflow),      32'h0);
      chk("t5_drop",     32'(drop_count),    32'h0);
      chk("t5_full",     32'(full),          32'h0);

      // Duplicate eviction
      bus.evict_valid = 1'b1; bus.evict_addr = 8'h22;
      tick();
      tick();
      bus.evict_valid = 1'b0;
`ifdef WB_COALESCE_EN
      chk("t6_pending", 32'(pending_count), 32'h1);
`else
      chk("t6_pending", 32'(pending_count), 32'h2);
`endif
      chk("t6_drop",     32'(drop_count),   32'h0);
      chk("t6_overflow", 32'(overflow),     32'h0);
      tick();
      chk("t6_head",     32'(bus.mem_addr), 32'h22);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
